// File: rtl/key_pkg.sv
// Scan-code constants, entry-state encoding and make-code decode helpers
// shared by the key entry sequencer, display and decode blocks.
package key_pkg;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_BKSP  = 8'h66;
   localparam logic [7:0] SC_ESC   = 8'h76;

   typedef enum logic [1:0] {
      ST_WAIT_LETTER = 2'd0,
      ST_WAIT_NUMBER = 2'd1,
      ST_WAIT_ENTER  = 2'd2,
      ST_PRESENT     = 2'd3
   } entry_state_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] idx;
   } key_idx_t;

   // Row letters A..J on a set-2 keyboard
   function automatic key_idx_t letter_index(input logic [7:0] code);
      key_idx_t r;
      r.hit = 1'b1;
      r.idx = 4'd0;
      case (code)
         8'h1C: r.idx = 4'd0;
         8'h32: r.idx = 4'd1;
         8'h21: r.idx = 4'd2;
         8'h23: r.idx = 4'd3;
         8'h24: r.idx = 4'd4;
         8'h2B: r.idx = 4'd5;
         8'h34: r.idx = 4'd6;
         8'h33: r.idx = 4'd7;
         8'h43: r.idx = 4'd8;
         8'h3B: r.idx = 4'd9;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

   // Top-row digits 0..9
   function automatic key_idx_t digit_index(input logic [7:0] code);
      key_idx_t r;
      r.hit = 1'b1;
      r.idx = 4'd0;
      case (code)
         8'h45: r.idx = 4'd0;
         8'h16: r.idx = 4'd1;
         8'h1E: r.idx = 4'd2;
         8'h26: r.idx = 4'd3;
         8'h25: r.idx = 4'd4;
         8'h2E: r.idx = 4'd5;
         8'h36: r.idx = 4'd6;
         8'h3D: r.idx = 4'd7;
         8'h3E: r.idx = 4'd8;
         8'h46: r.idx = 4'd9;
         default: r.hit = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/scan_prefix_filter.sv
// Swallows break (F0 xx) and extended (E0 xx, E0 F0 xx) sequences and
// forwards only plain make codes, combinationally, on the strobe cycle.
module scan_prefix_filter
   import key_pkg::*;
(
   input  logic       clock27,
   input  logic       reset,
   input  logic       scan_valid,
   input  logic [7:0] scan_code,
   output logic       make_valid,
   output logic [7:0] make_code
);

   logic brk;
   logic ext;

   always_ff @(posedge clock27) begin
      if (reset) begin
         brk <= 1'b0;
         ext <= 1'b0;
      end else if (scan_valid) begin
         if (scan_code == SC_EXT)
            ext <= 1'b1;
         else if (scan_code == SC_BREAK)
            brk <= 1'b1;
         else begin
            brk <= 1'b0;
            ext <= 1'b0;
         end
      end
   end

   assign make_valid = scan_valid && !brk && !ext &&
                       (scan_code != SC_EXT) && (scan_code != SC_BREAK);
   assign make_code  = scan_code;

endmodule

// File: rtl/key_entry_sequencer.sv
// Turns keyboard make codes into letter/digit/Enter grid coordinates and
// presents them to game logic over a valid/ready handshake.
module key_entry_sequencer
   import key_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 135000000,
   parameter int unsigned TMR_W          = 28
) (
   input  logic       clock27,
   input  logic       reset,
   input  logic       scan_valid,
   input  logic [7:0] scan_code,
   output logic       coord_valid,
   input  logic       coord_ready,
   output logic [3:0] coord_letter,
   output logic [3:0] coord_number,
   output logic [1:0] entry_state,
   output logic       key_error,
   output logic       timeout_pulse
);

   localparam logic [TMR_W-1:0] TMR_LAST =
      (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

   entry_state_t     state, state_n;
   logic [3:0]       letter_q, letter_n;
   logic [3:0]       number_q, number_n;
   logic [TMR_W-1:0] tmr, tmr_n;
   logic             err_n, to_n;
   logic             make_valid;
   logic [7:0]       make_code;
   key_idx_t         li, di;
   logic             is_bksp, is_esc, is_enter;

   scan_prefix_filter u_filter (
      .clock27    (clock27),
      .reset      (reset),
      .scan_valid (scan_valid),
      .scan_code  (scan_code),
      .make_valid (make_valid),
      .make_code  (make_code)
   );

   assign li       = letter_index(make_code);
   assign di       = digit_index(make_code);
   assign is_bksp  = (make_code == SC_BKSP);
   assign is_esc   = (make_code == SC_ESC);
   assign is_enter = (make_code == SC_ENTER);

   always_ff @(posedge clock27) begin
      if (reset) begin
         state         <= ST_WAIT_LETTER;
         letter_q      <= 4'd0;
         number_q      <= 4'd0;
         tmr           <= '0;
         key_error     <= 1'b0;
         timeout_pulse <= 1'b0;
      end else begin
         state         <= state_n;
         letter_q      <= letter_n;
         number_q      <= number_n;
         tmr           <= tmr_n;
         key_error     <= err_n;
         timeout_pulse <= to_n;
      end
   end

   always_comb begin
      state_n  = state;
      letter_n = letter_q;
      number_n = number_q;
      tmr_n    = tmr;
      err_n    = 1'b0;
      to_n     = 1'b0;

      case (state)
         ST_WAIT_LETTER: if (make_valid) begin
            if (li.hit) begin
               letter_n = li.idx;
               state_n  = ST_WAIT_NUMBER;
            end else if (!is_esc && !is_bksp)
               err_n = 1'b1;
         end
         ST_WAIT_NUMBER: if (make_valid) begin
            if (di.hit) begin
               number_n = di.idx;
               state_n  = ST_WAIT_ENTER;
            end else if (is_bksp || is_esc)
               state_n = ST_WAIT_LETTER;
            else
               err_n = 1'b1;
         end
         ST_WAIT_ENTER: if (make_valid) begin
            if (is_enter)
               state_n = ST_PRESENT;
            else if (is_bksp)
               state_n = ST_WAIT_NUMBER;
            else if (is_esc)
               state_n = ST_WAIT_LETTER;
            else
               err_n = 1'b1;
         end
         ST_PRESENT: if (coord_ready)
            state_n = ST_WAIT_LETTER;
         default: state_n = ST_WAIT_LETTER;
      endcase

      // In the timed states every state change is caused by a scan, so
      // clearing on scan_valid also covers clearing on a state change.
      if (TIMEOUT_CYCLES == 0 || scan_valid ||
          !(state == ST_WAIT_NUMBER || state == ST_WAIT_ENTER))
         tmr_n = '0;
      else if (tmr == TMR_LAST) begin
         tmr_n   = '0;
         to_n    = 1'b1;
         state_n = ST_WAIT_LETTER;
      end else
         tmr_n = tmr + 1'b1;
   end

   assign coord_valid  = (state == ST_PRESENT);
   assign coord_letter = letter_q;
   assign coord_number = number_q;
   assign entry_state  = state;

endmodule
